// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: one load/store at a time, WAIT_STATES wait cycles, single-cycle ready pulse.
// Optional MISALIGN_CHECK_EN adds an error output; misaligned stores are dropped and misaligned loads return 0.
//   state  | meaning
//   S_IDLE | no transaction; req is sampled
//   S_WAIT | request captured, counting down wait states
//   S_RESP | access performed on entry; ready high for this cycle
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clk,
   input  logic        nrst,
   input  logic        req,
   input  logic        write,
   input  logic [31:0] address,
   input  logic [31:0] write_data,
   input  logic [3:0]  byte_en,
   output logic [31:0] read_data,
   output logic        ready,
`ifdef MISALIGN_CHECK_EN
   output logic        error,
`endif
   output logic        busy
);

   localparam int AW = $clog2(DEPTH_WORDS);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

   state_t         state_q, state_d;
   logic [3:0]     cnt_q, cnt_d;
   logic           write_q;
   logic [AW-1:0]  idx_q;
   logic [31:0]    wdata_q;
   logic [3:0]     be_q;
   logic           misalign_q;
   logic [31:0]    rdata_q, rdata_d;
   logic           ready_q, ready_d;
   logic           busy_q, busy_d;
   logic           error_q, error_d;
   logic           access;
   logic           misalign_in;
   logic           acc_write;
   logic [AW-1:0]  acc_idx;
   logic [31:0]    acc_wdata;
   logic [3:0]     acc_be;
   logic           acc_misalign;
   logic [31:0]    mem_q [DEPTH_WORDS];
   logic           unused_bits;

`ifdef MISALIGN_CHECK_EN
   assign misalign_in = (address[1:0] != 2'b00);
   assign error       = error_q;
`else
   assign misalign_in = 1'b0;
`endif
   assign unused_bits = ^{address[31:AW+2], address[1:0], error_q};

   // With zero wait states the access happens on the acceptance edge, so use the live inputs there.
   always_comb begin
      if (state_q == S_IDLE) begin
         acc_write    = write;
         acc_idx      = address[AW+1:2];
         acc_wdata    = write_data;
         acc_be       = byte_en;
         acc_misalign = misalign_in;
      end else begin
         acc_write    = write_q;
         acc_idx      = idx_q;
         acc_wdata    = wdata_q;
         acc_be       = be_q;
         acc_misalign = misalign_q;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      access  = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req) begin
               busy_d = 1'b1;
               if (WAIT_STATES > 0) begin
                  state_d = S_WAIT;
                  cnt_d   = 4'(WAIT_STATES - 1);
               end else begin
                  state_d = S_RESP;
                  access  = 1'b1;
               end
            end
         end
         S_WAIT: begin
            if (cnt_q == 4'd0) begin
               state_d = S_RESP;
               access  = 1'b1;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_RESP: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
         default: begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
         end
      endcase
   end

   always_comb begin
      rdata_d = rdata_q;
      if (access && !acc_write) begin
         rdata_d = acc_misalign ? 32'h0 : mem_q[acc_idx];
      end
      ready_d = access;
      error_d = access && acc_misalign;
   end

   always_ff @(posedge clk or negedge nrst) begin
      if (!nrst) begin
         state_q    <= S_IDLE;
         cnt_q      <= 4'd0;
         write_q    <= 1'b0;
         idx_q      <= '0;
         wdata_q    <= 32'h0;
         be_q       <= 4'h0;
         misalign_q <= 1'b0;
         rdata_q    <= 32'h0;
         ready_q    <= 1'b0;
         busy_q     <= 1'b0;
         error_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
         error_q <= error_d;
         if (state_q == S_IDLE && req) begin
            write_q    <= write;
            idx_q      <= address[AW+1:2];
            wdata_q    <= write_data;
            be_q       <= byte_en;
            misalign_q <= misalign_in;
         end
      end
   end

   // Array is never reset; gating on nrst keeps an edge during reset from committing a store.
   always_ff @(posedge clk) begin
      if (nrst && access && acc_write && !acc_misalign) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) mem_q[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   assign read_data = rdata_q;
   assign ready     = ready_q;
   assign busy      = busy_q;

endmodule

// File: doc/dmem_responder.md
Name: dmem_responder

Overview:
Multi-cycle data-memory responder. It is the memory end of the load/store interface that the CPU datapath drives.
- Accepts one read or write request at a time through a req/ready handshake.
- Inserts a configurable number of wait states.
- Returns read data or commits write data with per-byte lane enables.
- Replaces the zero-latency data memory when the datapath is moved to a stall-capable (multi-cycle) memory interface.

Parameters:
DEPTH_WORDS, 256, number of 32-bit words in the array; must be a power of two and at least 2.
WAIT_STATES, 2, extra cycles between acceptance and response; legal range 0..15.

Ports:
clk  input  1  system clock; all state changes on the rising edge.
nrst  input  1  asynchronous active-low reset.
req  input  1  request strobe from the initiator; sampled only in IDLE.
write  input  1  1 = store, 0 = load; captured at acceptance.
address  input  32  byte address; captured at acceptance.
write_data  input  32  store data; captured at acceptance.
byte_en  input  4  store lane enables; bit i controls byte lane i (bits 8i+7:8i); captured at acceptance.
read_data  output  32  load result; registered.
ready  output  1  single-cycle completion pulse; registered.
busy  output  1  high while a transaction is in flight; registered.

Behaviour:
- Reset (nrst=0, asynchronous):
  - state=IDLE, wait counter=0, ready=0, busy=0, read_data=0.
  - Array contents are not cleared.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - If req=1 at a rising edge, the request is accepted: write, address, write_data and byte_en are latched, and busy goes to 1.
  - Next state is WAIT with counter=WAIT_STATES-1 when WAIT_STATES>0; otherwise next state is RESP.
- WAIT:
  - Counter decrements each cycle.
  - When counter=0, next state is RESP.
- RESP:
  - Entered at the edge where the access is performed. On that edge ready=1, and for a load read_data is updated.
  - The next edge returns to IDLE with ready=0 and busy=0.
- Latency and throughput:
  - Request accepted at edge N gives ready=1 during cycle N+1+WAIT_STATES, for exactly one cycle.
  - Minimum spacing between acceptances is WAIT_STATES+2 cycles.
- req while busy=1 (WAIT or RESP) is ignored: no queuing and no extra ready pulse. A req still held high on return to IDLE is accepted as a new request.
- Word index = address[log2(DEPTH_WORDS)+1:2]. Upper bits are ignored, so addresses wrap modulo DEPTH_WORDS*4. address[1:0] is ignored.
- Store:
  - Only lanes with byte_en[i]=1 are written, on the RESP-entry edge.
  - byte_en=0000 leaves the array unchanged but still completes with ready.
  - read_data holds its previous value on a store.
- Load:
  - Returns the full 32-bit word; byte_en is ignored.
  - read_data holds its value until the next load completes.
- A load issued after a completed store to the same word returns the new data.
- Reset mid-transaction aborts it:
  - No ready pulse is produced.
  - A store is not committed unless its RESP-entry edge preceded reset assertion.

Optional Feature:
MISALIGN_CHECK_EN
- Defined:
  - Adds output port error (1 bit, registered, reset 0).
  - If address[1:0]!=00 at acceptance, the transaction runs with normal latency, but stores are suppressed and loads return read_data=0.
  - error=1 in the same cycle as ready, cleared with it.
- Undefined: port absent; address[1:0] ignored as described above.

Test Plan:
1. nrst=0 mid-simulation, with any inputs -> ready=0, busy=0, read_data=0 immediately, without waiting for a clock edge.
2. WAIT_STATES=2: store 0xDEADBEEF at 0x10, byte_en=1111, accepted at edge 0 -> busy=1 from edge 0, ready=1 only in cycle 3. Then load 0x10 -> read_data=0xDEADBEEF during its ready cycle.
3. Store 0x0000AA00 at 0x10 with byte_en=0010 after test 2 -> load 0x10 returns 0xDEADAAEF. Store with byte_en=0000 -> ready pulses, data unchanged.
4. DEPTH_WORDS=256: store 0x12345678 at 0x400 -> load 0x000 returns 0x12345678 (wrap-around).
5. req held high continuously for 12 cycles, WAIT_STATES=2 -> exactly 3 ready pulses, at cycles 3, 7 and 11; no acceptance while busy=1.
6. Store 0xCAFEF00D to 0x20 (old value 0x11111111); pulse nrst=0 during WAIT -> no ready pulse. Subsequent load 0x20 returns 0x11111111. With MISALIGN_CHECK_EN, load 0x22 -> error=1 and read_data=0 in the ready cycle.
